// File: rtl/priority_encoder_if.sv
// Request/result bundle for the priority encoder: request vector and enable in,
// registered index and valid flag out.
interface priority_encoder_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OUT_W = 4
);
  logic             En;
  logic [WIDTH-1:0] p;
  logic [OUT_W-1:0] y;
  logic             VALID;

  modport master (output En, output p, input y, input VALID);
  modport slave  (input En, input p, output y, output VALID);
endinterface

// File: rtl/priority_encoder.sv
// Highest-index-wins priority encoder with a single registered output stage.
// Result appears one cycle after p/En are sampled; synchronous active-high reset.
module priority_encoder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OUT_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  priority_encoder_if.slave   bus
);

  logic [OUT_W-1:0] w_y;
  logic             w_valid;
  logic [OUT_W-1:0] r_y;
  logic             r_valid;

  // Ascending scan: later (higher) set bits overwrite lower ones.
  always_comb begin
    w_y     = '0;
    w_valid = 1'b0;
    if (bus.En) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (bus.p[i]) begin
          w_y     = OUT_W'(i);
          w_valid = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_y     <= w_y;
      r_valid <= w_valid;
    end
  end

  assign bus.y     = r_y;
  assign bus.VALID = r_valid;

endmodule

// File: tb/tb_priority_encoder.sv
// Scoreboard bench for priority_encoder: expected results are queued at drive
// time from an independent model and popped one cycle later against the outputs.
module tb_priority_encoder;

  typedef struct packed {
    logic [3:0] y;
    logic       valid;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  priority_encoder_if #(.WIDTH(16), .OUT_W(4)) bus ();

  priority_encoder #(.WIDTH(16), .OUT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: scan from the top bit down, stop at the first set bit.
  function automatic exp_t model(input logic r, input logic en, input logic [15:0] pv);
    exp_t e;
    int   k;
    e = '0;
    if (!r && en) begin
      k = 15;
      while (k >= 0 && !pv[k]) k--;
      if (k >= 0) begin
        e.y     = 4'(k);
        e.valid = 1'b1;
      end
    end
    return e;
  endfunction

  // Drive one cycle of stimulus on the falling edge, then compare after the rising edge.
  task automatic step(input string tag, input logic r, input logic en, input logic [15:0] pv);
    exp_t e;
    @(negedge clk);
    rst    = r;
    bus.En = en;
    bus.p  = pv;
    sb.push_back(model(r, en, pv));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_y"},     8'(bus.y),     8'(e.y));
      check({tag, "_valid"}, 8'(bus.VALID), 8'(e.valid));
    end
  endtask

  initial begin
    logic [3:0] held_y;
    logic       held_v;
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    bus.En  = 1'b0;
    bus.p   = '0;

    // Reset state, with reset overriding an active request
    step("reset0", 1'b1, 1'b1, 16'hFFFF);
    check("reset0_y_const", 8'(bus.y), 8'h00);
    check("reset0_v_const", 8'(bus.VALID), 8'h00);

    // Thermometer sweep
    for (int k = 1; k <= 15; k++) begin
      step($sformatf("therm%0d", k), 1'b0, 1'b1, 16'((32'd1 << k) - 32'd1));
      check($sformatf("therm%0d_y_const", k), 8'(bus.y), 8'(k - 1));
    end

    // Enable gating
    step("en_off", 1'b0, 1'b0, 16'h007F);
    step("en_on",  1'b0, 1'b1, 16'h00FF);
    check("en_on_y_const", 8'(bus.y), 8'd7);

    // Zero input versus request 0
    step("zero",  1'b0, 1'b1, 16'h0000);
    check("zero_v_const", 8'(bus.VALID), 8'd0);
    step("one",   1'b0, 1'b1, 16'h0001);
    check("one_v_const", 8'(bus.VALID), 8'd1);

    // Extremes
    step("top",   1'b0, 1'b1, 16'h8000);
    step("all",   1'b0, 1'b1, 16'hFFFF);
    check("all_y_const", 8'(bus.y), 8'd15);
    step("after", 1'b0, 1'b1, 16'h0003);
    check("after_y_const", 8'(bus.y), 8'd1);

    // Inputs changing between edges must not disturb registered outputs
    held_y = bus.y;
    held_v = bus.VALID;
    bus.p  = 16'h4000;
    #2;
    bus.En = 1'b0;
    #1;
    check("glitch_y", 8'(bus.y), 8'd1);
    check("glitch_v", 8'(bus.VALID), 8'(held_v));
    check("glitch_y_hold", 8'(bus.y), 8'(held_y));

    // Mid-stream reset, then release
    step("mid_rst", 1'b1, 1'b1, 16'h0FFF);
    step("release", 1'b0, 1'b1, 16'h0FFF);
    check("release_y_const", 8'(bus.y), 8'd11);

    // Exhaustive sweep with enable high
    for (int v = 0; v < 65536; v++) begin
      step("exh", 1'b0, 1'b1, 16'(v));
    end

    check("sb_drained", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/priority_encoder.md
PRIORITY_ENCODER -- requirements
Module: priority_encoder

Interface
REQ-001 Parameter WIDTH, default 16, number of request inputs; this revision supports only 16.
REQ-002 Parameter OUT_W, default 4, encoded index width; SHALL equal log2(WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 En  input  1  encoder enable; 1 = encode, 0 = outputs forced invalid.
REQ-006 p  input  16  request vector; bit i = request i; bit 15 highest priority, bit 0 lowest.
REQ-007 y  output  4  registered index of the highest-priority asserted request.
REQ-008 VALID  output  1  registered flag; 1 = y holds a valid index.

Function
REQ-009 Priority SHALL be highest-index-wins: y = largest i such that p[i] = 1, regardless of lower bits.
REQ-010 Lower asserted bits SHALL never affect y when a higher bit is set (e.g. p = 0x00FF -> y = 7).
REQ-011 With En = 1 and p != 0: VALID SHALL be 1 and y SHALL be the encoded index.
REQ-012 With En = 1 and p = 0: VALID SHALL be 0 and y SHALL be 0.
REQ-013 With En = 0: VALID SHALL be 0 and y SHALL be 0, independent of p.
REQ-014 Encoding SHALL be combinational from p/En into the output registers; y and VALID update on the first rising clk edge after inputs are sampled (latency exactly 1 cycle).
REQ-015 A new p/En value SHALL be accepted every cycle; no handshake, no stall, no internal state beyond the output registers.
REQ-016 Outputs SHALL hold their registered values between clock edges; input glitches between edges SHALL have no effect.
REQ-017 p = 0x0001 SHALL give y = 0, VALID = 1 (VALID distinguishes request 0 from no request).
REQ-018 p = 0x8000 or p = 0xFFFF SHALL give y = 15, VALID = 1.
REQ-019 No X/Z propagation handling required; inputs are assumed fully driven.

Reset
REQ-020 When rst = 1 at a rising clk edge, y SHALL become 0 and VALID SHALL become 0.
REQ-021 rst SHALL take priority over En and p in the same cycle.
REQ-022 On the first edge with rst = 0, outputs SHALL reflect that cycle's p/En per REQ-009..REQ-013.
REQ-023 Reset asserted mid-stream SHALL discard the pending result; no result from before reset appears afterward.

Verification
REQ-024 Thermometer sweep, En = 1: p = 0x0001, 0x0003, 0x0007 ... 0x7FFF, one per cycle -> y = 0, 1, 2 ... 14 with VALID = 1, each one cycle after drive.
REQ-025 Enable gating: p = 0x007F with En = 0 -> y = 0, VALID = 0; next cycle p = 0x00FF with En = 1 -> y = 7, VALID = 1.
REQ-026 Zero input: En = 1, p = 0x0000 -> y = 0, VALID = 0; then p = 0x0001 -> y = 0, VALID = 1.
REQ-027 Extremes: p = 0x8000 -> y = 15; p = 0xFFFF -> y = 15; p = 0x0003 following 0xFFFF -> y = 1; VALID = 1 throughout.
REQ-028 Reset: drive p = 0x0FFF, En = 1 with rst = 1 -> y = 0, VALID = 0; release rst -> next edge y = 11, VALID = 1.
REQ-029 Exhaustive check: all 65536 p values with En = 1 against a reference model -> y and VALID match after 1-cycle latency.
